pwm_capture: RTL and testbench

Measures an incoming PWM waveform and recovers its 8-bit duty level, the inverse of the team's PWM generator. It sits on the input side of the design (loopback self-test, external PWM sensors) and turns an asynchronous pulse train into a registered level, a one-cycle valid strobe and period-health flags. It also handles the degenerate 0 % and 100 % duty cases, which produce no edges, through a timeout.

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_capture_sync_2ff.sv | 22 ++
 rtl/pwm_capture.sv | 106 ++++++++++
 tb/tb_pwm_capture.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM generator/capture pair.
package pwm_pkg;
  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    MEASURE = 2'd1,
    STUCK   = 2'd2
  } pwm_cap_state_t;

  localparam int PWM_LEVEL_W         = 8;
  localparam int PWM_PERIOD_DEFAULT  = 256;
  localparam int PWM_TIMEOUT_DEFAULT = 512;
  localparam int PWM_CNT_W           = 10;
endpackage

// File: rtl/pwm_capture_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, synchronous active-high reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/pwm_capture.sv
// Recovers the duty level of an asynchronous PWM line; constant lines are
// reported through a timeout as stuck-low (level 0) or stuck-high (level 255).
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int PERIOD  = PWM_PERIOD_DEFAULT,
  parameter int TIMEOUT = PWM_TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pwm_in,
  output logic [PWM_LEVEL_W-1:0] level,
  output logic                   valid,
  output logic                   period_ok,
  output logic                   stuck
);
  typedef logic [PWM_CNT_W-1:0] cnt_t;

  localparam cnt_t PERIOD_C  = cnt_t'(PERIOD);
  localparam cnt_t TIMEOUT_C = cnt_t'(TIMEOUT);

  function automatic cnt_t sat_inc(input cnt_t v, input logic en);
    if (en && (v != '1)) return v + cnt_t'(1);
    return v;
  endfunction

  function automatic logic [PWM_LEVEL_W-1:0] sat_level(input cnt_t v);
    if (v > cnt_t'(255)) return '1;
    return v[PWM_LEVEL_W-1:0];
  endfunction

  pwm_cap_state_t         state_q;
  cnt_t                   period_cnt_q, period_cnt_d;
  cnt_t                   high_cnt_q, high_cnt_d;
  logic                   pwm_s;
  logic                   pwm_d_q;
  logic                   rise;
  logic                   timeout;
  logic [PWM_LEVEL_W-1:0] level_q;
  logic                   valid_q;
  logic                   period_ok_q;
  logic                   stuck_q;

  sync_2ff u_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (pwm_in),
    .q_o   (pwm_s)
  );

  assign rise    = pwm_s & ~pwm_d_q;
  assign timeout = (period_cnt_q == TIMEOUT_C) && !rise;

  // A rise always restarts the frame; a timeout restarts from zero so the
  // next timeout lands TIMEOUT+1 cycles later.
  always_comb begin
    period_cnt_d = sat_inc(period_cnt_q, 1'b1);
    high_cnt_d   = sat_inc(high_cnt_q, (state_q == MEASURE) && pwm_s);
    if (rise) begin
      period_cnt_d = cnt_t'(1);
      high_cnt_d   = cnt_t'(1);
    end else if (timeout) begin
      period_cnt_d = '0;
      high_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ACQUIRE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      pwm_d_q      <= 1'b0;
      level_q      <= '0;
      valid_q      <= 1'b0;
      period_ok_q  <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      pwm_d_q      <= pwm_s;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      valid_q      <= 1'b0;
      if (rise) begin
        state_q <= MEASURE;
        // Only a rise that closes a full frame yields a result.
        if (state_q == MEASURE) begin
          level_q     <= sat_level(high_cnt_q);
          period_ok_q <= (period_cnt_q == PERIOD_C);
          stuck_q     <= 1'b0;
          valid_q     <= 1'b1;
        end
      end else if (timeout) begin
        state_q     <= STUCK;
        level_q     <= pwm_s ? '1 : '0;
        period_ok_q <= 1'b0;
        stuck_q     <= 1'b1;
        valid_q     <= 1'b1;
      end
    end
  end

  assign level     = level_q;
  assign valid     = valid_q;
  assign period_ok = period_ok_q;
  assign stuck     = stuck_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: constant lines, several duty patterns and mid-frame reset.
module tb_pwm_capture;
  logic       clk;
  logic       reset;
  logic       pwm_in;
  logic [7:0] level;
  logic       valid;
  logic       period_ok;
  logic       stuck;

  int checks = 0;
  int errors = 0;

  int mode;
  int hi;
  int per;
  int ph_start;
  int restart;

  pwm_capture #(.PERIOD(256), .TIMEOUT(512)) dut (
    .clk       (clk),
    .reset     (reset),
    .pwm_in    (pwm_in),
    .level     (level),
    .valid     (valid),
    .period_ok (period_ok),
    .stuck     (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line generator: mode 0 low, 1 high, 2 pattern of hi high cycles per per.
  initial begin
    int ph;
    int seen;
    ph = 0;
    seen = 0;
    pwm_in = 1'b0;
    forever begin
      @(negedge clk);
      if (restart != seen) begin
        seen = restart;
        ph = ph_start;
      end
      case (mode)
        0: pwm_in = 1'b0;
        1: pwm_in = 1'b1;
        default: begin
          pwm_in = (ph < hi);
          ph = ph + 1;
          if (ph >= per) ph = 0;
        end
      endcase
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns the number of clock edges until valid is seen, or -1 on timeout.
  task automatic wait_valid(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        n = i;
        return;
      end
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    mode = 0;
    hi = 0;
    per = 256;
    ph_start = 0;
    restart = 0;

    step(3);
    chk("rst_level", level, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ok", period_ok, 0);
    chk("rst_stuck", stuck, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Constant low from reset.
    wait_valid(600, n);
    chk("low_gap1", n, 513);
    chk("low_level", level, 0);
    chk("low_stuck", stuck, 1);
    chk("low_ok", period_ok, 0);
    wait_valid(600, n);
    chk("low_gap2", n, 513);
    step(1);
    chk("low_strobe_width", valid, 0);
    chk("low_hold_stuck", stuck, 1);

    // Line goes high and stays there.
    mode = 1;
    wait_valid(700, n);
    chk("high_gap1", n, 515);
    chk("high_level", level, 255);
    chk("high_stuck", stuck, 1);
    chk("high_ok", period_ok, 0);
    wait_valid(600, n);
    chk("high_gap2", n, 513);
    chk("high_level2", level, 255);

    // 64/256 pattern starting in its low phase: first rise only sets phase.
    hi = 64;
    per = 256;
    ph_start = 64;
    restart = restart + 1;
    mode = 2;
    wait_valid(700, n);
    chk("p64_first", n, 451);
    chk("p64_level", level, 64);
    chk("p64_stuck", stuck, 0);
    chk("p64_ok", period_ok, 1);

    // 128/256.
    hi = 128;
    wait_valid(300, n);
    chk("p128_gap", n, 256);
    chk("p128_level", level, 128);
    chk("p128_ok", period_ok, 1);
    chk("p128_stuck", stuck, 0);
    step(1);
    chk("p128_strobe_width", valid, 0);
    chk("p128_hold_level", level, 128);
    wait_valid(300, n);
    chk("p128_gap2", n, 255);
    chk("p128_level2", level, 128);

    // 300/100: high count clips to 255, period is wrong.
    hi = 300;
    per = 400;
    wait_valid(500, n);
    chk("p300_gap", n, 400);
    chk("p300_level", level, 255);
    chk("p300_ok", period_ok, 0);

    // 10/190.
    hi = 10;
    per = 200;
    wait_valid(300, n);
    chk("p10_gap", n, 200);
    chk("p10_level", level, 10);
    chk("p10_ok", period_ok, 0);

    // Back to 128/256, then reset during the low phase.
    hi = 128;
    per = 256;
    wait_valid(300, n);
    chk("p128b_gap", n, 256);
    chk("p128b_ok", period_ok, 1);
    step(150);
    reset = 1'b1;
    step(1);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_ok", period_ok, 0);
    chk("mid_rst_stuck", stuck, 0);
    step(1);
    reset = 1'b0;
    wait_valid(500, n);
    chk("post_rst_gap", n, 360);
    chk("post_rst_level", level, 128);
    chk("post_rst_ok", period_ok, 1);
    chk("post_rst_stuck", stuck, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
